// File: rtl/graphics_pixel_writer_if.sv
// Stream and memory-bus interfaces for the graphics pixel writer.
// graphics_st_if carries pixel beats (Avalon-ST); graphics_mm_if is the
// frame-buffer write port (Avalon-MM write-only master).

interface graphics_st_if #(
  parameter int DATA_WIDTH = 40
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

interface graphics_mm_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  write;
  logic                  waitrequest;

  modport master (output address, output writedata, output write, input waitrequest);
  modport slave  (input address, input writedata, input write, output waitrequest);
endinterface

// File: rtl/graphics_pixel_writer.sv
// Pixel writer: buffers pixel beats from the drawing primitives, drops
// off-screen pixels, and commits the rest to the frame buffer in order.

package graphics_pkg;
  localparam int COORD_DATA_WIDTH = 12;
  localparam int COLOR_WIDTH      = 12;
  localparam int PAD_WIDTH        = 4;
  localparam int ST_DATA_WIDTH    = PAD_WIDTH + 2 * COORD_DATA_WIDTH + COLOR_WIDTH;

  typedef logic signed [COORD_DATA_WIDTH-1:0] coord_t;
  typedef logic        [COLOR_WIDTH-1:0]      color_t;

  typedef struct packed {
    logic [PAD_WIDTH-1:0] pad;
    coord_t               x;
    coord_t               y;
    color_t               color;
  } pixel_t;
endpackage

module graphics_pixel_writer
  import graphics_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FB_BASE       = 0,
  parameter int FB_ADDR_WIDTH = 19,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  graphics_st_if.slave         st,
  graphics_mm_if.master        mm,
  output logic                 idle,
  output logic [15:0]          clip_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [FB_ADDR_WIDTH-1:0] addr_t;

  // FIFO entry: the beat without its padding.
  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t color;
  } entry_t;

  pixel_t in_pix;
  entry_t in_entry;
  logic   unused_pad;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  entry_t             head;
  logic               head_clip;
  addr_t              head_row;

  logic               s1_valid;
  logic               s1_clip;
  coord_t             s1_x;
  color_t             s1_color;
  addr_t              s1_row;

  logic               s1_advance;
  logic               s2_load;
  logic               s2_done;

  assign in_pix     = st.data;
  assign in_entry   = '{x: in_pix.x, y: in_pix.y, color: in_pix.color};
  assign unused_pad = ^in_pix.pad;

  // Handshake, pipeline-advance and S1 pre-computation from the FIFO head.
  always_comb begin
    // NOTE: every signal assigned in this block is given a value on every pass, so no latch can be inferred.
    fifo_empty = (count == '0);
    push       = st.valid && st.ready;
    s2_done    = mm.write && !mm.waitrequest;
    s1_advance = s1_valid && (s1_clip || !mm.write || s2_done);
    s2_load    = s1_advance && !s1_clip;
    pop        = !fifo_empty && (!s1_valid || s1_advance);
    count_next = count + CNT_W'(push) - CNT_W'(pop);

    head       = fifo_mem[rd_ptr];
    head_clip  = (int'(head.x) < 0) || (int'(head.x) >= SCREEN_WIDTH) ||
                 (int'(head.y) < 0) || (int'(head.y) >= SCREEN_HEIGHT);
    head_row   = addr_t'(head.y) * addr_t'(SCREEN_WIDTH);
  end

  // FIFO storage: written on accept only.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale contents are never read.
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  // FIFO control, S1/S2 pipeline registers, status flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      st.ready     <= 1'b0;
      s1_valid     <= 1'b0;
      s1_clip      <= 1'b0;
      s1_x         <= '0;
      s1_color     <= '0;
      s1_row       <= '0;
      mm.write     <= 1'b0;
      mm.address   <= '0;
      mm.writedata <= '0;
      idle         <= 1'b1;
      clip_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      st.ready <= (count_next < CNT_W'(FIFO_DEPTH));

      if (pop) begin
        s1_valid <= 1'b1;
        s1_clip  <= head_clip;
        s1_x     <= head.x;
        s1_color <= head.color;
        s1_row   <= head_row;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end

      if (s1_advance && s1_clip && (clip_count != 16'hFFFF))
        clip_count <= clip_count + 1'b1;

      // The write is held until the memory accepts it; a waiting S1 pixel
      // replaces it on the completing edge, keeping 1 write per clock.
      if (s2_load) begin
        mm.write     <= 1'b1;
        mm.address   <= addr_t'(FB_BASE) + s1_row + addr_t'(s1_x);
        mm.writedata <= s1_color;
      end else if (s2_done) begin
        mm.write     <= 1'b0;
      end

      idle <= fifo_empty && !s1_valid && !mm.write;
    end
  end

endmodule

// File: tb/tb_graphics_pixel_writer.sv
// Self-checking bench for graphics_pixel_writer: directed scenarios plus
// random pixels/stalls checked against a pixel-level reference model.

module tb_graphics_pixel_writer;
  import graphics_pkg::*;

  localparam int W         = 640;
  localparam int H         = 480;
  localparam int AW        = 19;
  localparam int DEPTH     = 4;
  localparam int MAIN_BASE = 0;
  localparam int WRAP_BASE = (1 << AW) - 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  graphics_st_if #(.DATA_WIDTH(ST_DATA_WIDTH))            st ();
  graphics_mm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(COLOR_WIDTH)) mm ();
  graphics_st_if #(.DATA_WIDTH(ST_DATA_WIDTH))            wst ();
  graphics_mm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(COLOR_WIDTH)) wmm ();

  logic        idle;
  logic [15:0] clip_count;
  logic        widle;
  logic [15:0] wclip;

  graphics_pixel_writer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FB_BASE(MAIN_BASE),
    .FB_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .st(st), .mm(mm), .idle(idle), .clip_count(clip_count)
  );

  graphics_pixel_writer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FB_BASE(WRAP_BASE),
    .FB_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut_wrap (
    .clk(clk), .reset(reset), .st(wst), .mm(wmm), .idle(widle), .clip_count(wclip)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  clip_model  = 0;
  int  accepted    = 0;
  int  writes_seen = 0;
  int  cyc         = 0;
  int  trk_first   = -1;
  int  trk_last    = -1;

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  function automatic pixel_t mk(input int x, input int y, input int c);
    pixel_t p;
    p.pad   = '0;
    p.x     = coord_t'(x);
    p.y     = coord_t'(y);
    p.color = color_t'(c);
    return p;
  endfunction

  pixel_t                 mon_p;
  wr_t                    mon_e;
  bit                     prev_stall = 1'b0;
  logic [AW-1:0]          prev_addr;
  logic [COLOR_WIDTH-1:0] prev_data;

  // Monitor: record accepts into the model, score every completed write,
  // and check the bus is held stable across stalls.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (st.valid && st.ready) begin
        mon_p = st.data;
        accepted++;
        if (on_screen(int'(mon_p.x), int'(mon_p.y)))
          exp_q.push_back('{(MAIN_BASE + int'(mon_p.y) * W + int'(mon_p.x)) % (1 << AW),
                            int'(mon_p.color)});
        else
          clip_model++;
      end
      if (prev_stall) begin
        check("stall_write_held", mm.write, 1'b1);
        check("stall_addr_held", mm.address, prev_addr);
        check("stall_data_held", mm.writedata, prev_data);
      end
      if (mm.write && !mm.waitrequest) begin
        check("write_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mm.address, mon_e.addr);
          check("wr_data", mm.writedata, mon_e.data);
        end
        writes_seen++;
        if (trk_first < 0) trk_first = cyc;
        trk_last = cyc;
      end
      prev_stall = mm.write && mm.waitrequest;
      prev_addr  = mm.address;
      prev_data  = mm.writedata;
    end
  end

  // ---------------- stimulus helpers (start/end at posedge+1) ----------------
  task automatic send_pix(input int x, input int y, input int c);
    int waited = 0;
    st.data  = mk(x, y, c);
    st.valid = 1'b1;
    @(negedge clk);
    while (!st.ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("send_timeout", 64'(waited), 0);
    @(posedge clk);
    #1;
    st.valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (idle !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, idle, 1'b1);
  endtask

  int  wbase;
  int  abase;
  int  rx, ry;
  bit  rnd_done;

  initial begin
    st.valid        = 1'b0;
    st.data         = '0;
    mm.waitrequest  = 1'b0;
    wst.valid       = 1'b0;
    wst.data        = '0;
    wmm.waitrequest = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", st.ready, 1'b0);
    check("rst_write", mm.write, 1'b0);
    check("rst_addr", mm.address, 0);
    check("rst_data", mm.writedata, 0);
    check("rst_idle", idle, 1'b1);
    check("rst_clip", clip_count, 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", st.ready, 1'b1);

    // Single pixel and latency
    send_pix(10, 2, 5);
    check("lat_e0", mm.write, 1'b0);
    @(posedge clk); #1;
    check("lat_e1", mm.write, 1'b0);
    @(posedge clk); #1;
    check("lat_e2", mm.write, 1'b1);
    check("single_addr", mm.address, 2 * W + 10);
    check("single_data", mm.writedata, 5);
    wait_idle("single_idle");
    check("single_q_empty", exp_q.size(), 0);

    // Streaming horizontal line, no stalls
    wbase = writes_seen;
    trk_first = -1;
    for (int i = 0; i < 16; i++) begin
      check("stream_ready", st.ready, 1'b1);
      send_pix(i, 0, i + 1);
    end
    wait_idle("stream_idle");
    check("stream_count", writes_seen - wbase, 16);
    check("stream_back_to_back", trk_last - trk_first, 15);

    // Backpressure: 20-cycle stall during a 10-pixel stream
    wbase = writes_seen;
    abase = accepted;
    mm.waitrequest = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_pix(20 + i, 7, i + 1);
      end
      begin
        repeat (20) @(posedge clk);
        #2;
        check("bp_outstanding", accepted - abase, DEPTH + 2);
        check("bp_ready_low", st.ready, 1'b0);
        check("bp_no_writes", writes_seen - wbase, 0);
        mm.waitrequest = 1'b0;
      end
    join
    wait_idle("bp_idle");
    check("bp_count", writes_seen - wbase, 10);
    check("bp_q_empty", exp_q.size(), 0);

    // Clipping boundaries
    wbase = writes_seen;
    send_pix(-1, 0, 1);
    send_pix(W, 5, 2);
    send_pix(3, H, 3);
    send_pix(5, -2, 4);
    send_pix(W - 1, H - 1, 6);
    wait_idle("clip_idle");
    check("clip_count", clip_count, sat16(clip_model));
    check("clip_writes", writes_seen - wbase, 1);
    check("clip_q_empty", exp_q.size(), 0);

    // Random pixels with random stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++)
          send_pix(int'($urandom_range(0, 680)) - 20, int'($urandom_range(0, 520)) - 20,
                   int'($urandom_range(0, 4095)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          mm.waitrequest = ($urandom_range(0, 2) == 0);
        end
        mm.waitrequest = 1'b0;
      end
    join
    wait_idle("rnd_idle");
    check("rnd_q_empty", exp_q.size(), 0);
    check("rnd_clip_count", clip_count, sat16(clip_model));

    // Saturation of the clip counter
    for (int i = 0; i < 65540; i++) begin
      rx = int'($urandom_range(0, W - 1));
      ry = int'($urandom_range(0, H - 1));
      case ($urandom_range(0, 3))
        0:       rx = -1 - int'($urandom_range(0, 1000));
        1:       rx = W + int'($urandom_range(0, 1000));
        2:       ry = -1 - int'($urandom_range(0, 1000));
        default: ry = H + int'($urandom_range(0, 1000));
      endcase
      send_pix(rx, ry, i);
    end
    wait_idle("sat_idle");
    check("sat_clip_count", clip_count, sat16(clip_model));

    // Address wrap on the second instance
    wst.data  = mk(5, 0, 3);
    wst.valid = 1'b1;
    @(negedge clk);
    check("wrap_ready", wst.ready, 1'b1);
    @(posedge clk); #1;
    wst.valid = 1'b0;
    for (int n = 0; n < 10 && !wmm.write; n++) begin
      @(posedge clk); #1;
    end
    check("wrap_write", wmm.write, 1'b1);
    check("wrap_addr", wmm.address, (WRAP_BASE + 0 * W + 5) % (1 << AW));
    check("wrap_data", wmm.writedata, 3);

    // Reset in the middle of a stall with the FIFO full
    mm.waitrequest = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) send_pix(100 + i, 9, i + 7);
    check("pre_rst_ready", st.ready, 1'b0);
    check("pre_rst_write", mm.write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_write", mm.write, 1'b0);
    check("mid_rst_addr", mm.address, 0);
    check("mid_rst_data", mm.writedata, 0);
    check("mid_rst_ready", st.ready, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    check("mid_rst_clip", clip_count, 0);
    exp_q.delete();
    clip_model = 0;
    mm.waitrequest = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    wbase = writes_seen;
    send_pix(7, 3, 10);
    wait_idle("post_rst_idle");
    check("post_rst_writes", writes_seen - wbase, 1);
    check("post_rst_q_empty", exp_q.size(), 0);
    check("post_rst_clip", clip_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
